// File: rtl/vector_fp_regfile.sv
// Four-bank vector FP register file: three-operand forked reads and a byte-strobed write port,
// with round-robin arbitration per bank. Define VECTOR_FP_REGFILE_TRACE_EN for a per-transfer trace.
module vector_fp_regfile #(
  parameter int DATA_WIDTH     = 64,
  parameter int MEM_ADDR_WIDTH = 6,
  parameter int TAG_WIDTH      = 8,
  localparam int ADDR_WIDTH    = MEM_ADDR_WIDTH + 2,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [2:0][ADDR_WIDTH-1:0]          raddr_i,
  input  logic [2:0]                          ren_i,
  input  logic [TAG_WIDTH-1:0]                rtag_i,
  input  logic                                rvalid_i,
  output logic                                rready_o,
  output logic [2:0][DATA_WIDTH-1:0]          rdata_o,
  output logic [TAG_WIDTH-1:0]                rtag_o,
  output logic                                rvalid_o,
  input  logic                                rready_i,
  input  logic                                wr_valid_i,
  output logic                                wr_ready_o,
  input  logic [ADDR_WIDTH-1:0]               wr_addr_i,
  input  logic [DATA_WIDTH-1:0]               wr_data_i,
  input  logic [STRB_WIDTH-1:0]               wr_strb_i,
  output logic                                wr_rsp_valid_o,
  output logic [3:0]                          mem_req_o,
  input  logic [3:0]                          mem_gnt_i,
  output logic [3:0][MEM_ADDR_WIDTH-1:0]      mem_addr_o,
  output logic [3:0]                          mem_we_o,
  output logic [3:0][DATA_WIDTH-1:0]          mem_wdata_o,
  output logic [3:0][STRB_WIDTH-1:0]          mem_strb_o,
  input  logic [3:0][DATA_WIDTH-1:0]          mem_rdata_i
);

  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       hit;
    rr_pick = ptr;
    hit     = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!hit && req[idx]) begin
        rr_pick = idx;
        hit     = 1'b1;
      end
    end
  endfunction

  logic [2:0]            pending, trk_room, buf_ok, op_req, op_gnt;
  logic [2:0]            opd_vld, opd_pop, trk_head, trk_ok;
  logic [1:0]            op_bank [3];
  logic [3:0]            acc, done_q;
  logic                  wr_req, wr_gnt, out_fire;
  logic [1:0]            wr_bank;
  logic [3:0]            bank_req [4];
  logic [1:0]            sel [4];
  logic [1:0]            rr_q [4];
  logic [DATA_WIDTH-1:0] opd_data [3];

  logic                  trk_mem_q [3][2];
  logic [2:0]            trk_rd_q, trk_wr_q;
  logic [1:0]            trk_cnt_q [3];
  logic [TAG_WIDTH-1:0]  tag_mem [2];
  logic                  tag_rd_q, tag_wr_q;
  logic [1:0]            tag_cnt_q;
  logic [2:0]            buf_vld_q;
  logic [DATA_WIDTH-1:0] buf_data [3];
  logic [2:0]            rd_vld_p1;
  logic [1:0]            rd_bank_p1 [3];
  logic                  wr_rsp_vld_p1;

  // Result stage: fall-through operand buffers joined with the tag and track spill registers
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      opd_vld[i]  = buf_vld_q[i] | rd_vld_p1[i];
      opd_data[i] = buf_vld_q[i] ? buf_data[i] : mem_rdata_i[rd_bank_p1[i]];
      trk_head[i] = trk_mem_q[i][trk_rd_q[i]];
      trk_ok[i]   = (trk_cnt_q[i] != 2'd0) && (!trk_head[i] || opd_vld[i]);
    end
  end

  assign rvalid_o = !rst_i && (tag_cnt_q != 2'd0) && (&trk_ok);
  assign out_fire = rvalid_o && rready_i;
  assign rtag_o   = tag_mem[tag_rd_q];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      opd_pop[i] = out_fire && trk_head[i];
      rdata_o[i] = trk_head[i] ? opd_data[i] : '0;
    end
  end

  // Issue stage: an operand may only go to a bank if its buffer is free when the data returns
  always_comb begin
    wr_req  = wr_valid_i && !rst_i;
    wr_bank = wr_addr_i[1:0];
    for (int i = 0; i < 3; i++) begin
      pending[i]  = rvalid_i && !done_q[i];
      trk_room[i] = (trk_cnt_q[i] != 2'd2);
      buf_ok[i]   = !opd_vld[i] || opd_pop[i];
      op_bank[i]  = raddr_i[i][1:0];
      op_req[i]   = !rst_i && pending[i] && ren_i[i] && trk_room[i] && buf_ok[i];
    end
  end

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      bank_req[b][3] = wr_req && (wr_bank == 2'(b));
      for (int i = 0; i < 3; i++)
        bank_req[b][i] = op_req[i] && (op_bank[i] == 2'(b));
    end
  end

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      sel[b]         = rr_pick(bank_req[b], rr_q[b]);
      mem_req_o[b]   = |bank_req[b];
      mem_we_o[b]    = mem_req_o[b] && (sel[b] == 2'd3);
      mem_wdata_o[b] = wr_data_i;
      mem_strb_o[b]  = wr_strb_i;
      case (sel[b])
        2'd0:    mem_addr_o[b] = raddr_i[0][ADDR_WIDTH-1:2];
        2'd1:    mem_addr_o[b] = raddr_i[1][ADDR_WIDTH-1:2];
        2'd2:    mem_addr_o[b] = raddr_i[2][ADDR_WIDTH-1:2];
        default: mem_addr_o[b] = wr_addr_i[ADDR_WIDTH-1:2];
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      op_gnt[i] = op_req[i] && mem_gnt_i[op_bank[i]] && (sel[op_bank[i]] == 2'(i));
      acc[i]    = !rst_i && pending[i] && trk_room[i] && (ren_i[i] ? op_gnt[i] : 1'b1);
    end
    wr_gnt = wr_req && mem_gnt_i[wr_bank] && (sel[wr_bank] == 2'd3);
    acc[3] = !rst_i && rvalid_i && !done_q[3] && (tag_cnt_q != 2'd2);
  end

  assign rready_o       = !rst_i && rvalid_i && (&(done_q | acc));
  assign wr_ready_o     = wr_gnt;
  assign wr_rsp_valid_o = wr_rsp_vld_p1;

  // Bank-return stage: control state, cleared by reset so in-flight reads are dropped
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q        <= '0;
      rd_vld_p1     <= '0;
      buf_vld_q     <= '0;
      trk_rd_q      <= '0;
      trk_wr_q      <= '0;
      tag_rd_q      <= 1'b0;
      tag_wr_q      <= 1'b0;
      tag_cnt_q     <= '0;
      wr_rsp_vld_p1 <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        trk_cnt_q[i]    <= '0;
        trk_mem_q[i][0] <= 1'b0;
        trk_mem_q[i][1] <= 1'b0;
      end
      for (int b = 0; b < 4; b++) rr_q[b] <= '0;
    end else begin
      done_q        <= rready_o ? '0 : (done_q | acc);
      rd_vld_p1     <= op_gnt;
      wr_rsp_vld_p1 <= wr_gnt;
      for (int b = 0; b < 4; b++)
        if (mem_req_o[b] && mem_gnt_i[b]) rr_q[b] <= sel[b] + 2'd1;
      for (int i = 0; i < 3; i++) begin
        if (acc[i]) begin
          trk_mem_q[i][trk_wr_q[i]] <= ren_i[i];
          trk_wr_q[i]               <= ~trk_wr_q[i];
        end
        if (out_fire) trk_rd_q[i] <= ~trk_rd_q[i];
        trk_cnt_q[i] <= trk_cnt_q[i] + {1'b0, acc[i]} - {1'b0, out_fire};
        if (buf_vld_q[i]) begin
          if (opd_pop[i]) buf_vld_q[i] <= 1'b0;
        end else if (rd_vld_p1[i] && !opd_pop[i]) begin
          buf_vld_q[i] <= 1'b1;
        end
      end
      if (acc[3]) tag_wr_q <= ~tag_wr_q;
      if (out_fire) tag_rd_q <= ~tag_rd_q;
      tag_cnt_q <= tag_cnt_q + {1'b0, acc[3]} - {1'b0, out_fire};
    end
  end

  always_ff @(posedge clk_i) begin
    if (acc[3]) tag_mem[tag_wr_q] <= rtag_i;
    for (int i = 0; i < 3; i++) begin
      if (op_gnt[i]) rd_bank_p1[i] <= op_bank[i];
      if (!buf_vld_q[i] && rd_vld_p1[i]) buf_data[i] <= mem_rdata_i[rd_bank_p1[i]];
    end
  end

`ifdef VECTOR_FP_REGFILE_TRACE_EN
  always @(posedge clk_i) begin
    if (rready_o)
      $display("vector_fp_regfile: read addr=%h/%h/%h en=%b tag=%h",
               raddr_i[0], raddr_i[1], raddr_i[2], ren_i, rtag_i);
    if (wr_ready_o)
      $display("vector_fp_regfile: write addr=%h data=%h", wr_addr_i, wr_data_i);
  end
`endif

endmodule

// File: tb/tb_vector_fp_regfile.sv
// Self-checking bench for vector_fp_regfile: banked memory model plus a flat register-file
// reference that predicts every read result in request order.
module tb_vector_fp_regfile;
  localparam int DW = 64;
  localparam int AW = 8;
  localparam int TW = 8;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [2:0][AW-1:0]   raddr_i;
  logic [2:0]           ren_i;
  logic [TW-1:0]        rtag_i;
  logic                 rvalid_i;
  logic                 rready_o;
  logic [2:0][DW-1:0]   rdata_o;
  logic [TW-1:0]        rtag_o;
  logic                 rvalid_o;
  logic                 rready_i;
  logic                 wr_valid_i;
  logic                 wr_ready_o;
  logic [AW-1:0]        wr_addr_i;
  logic [DW-1:0]        wr_data_i;
  logic [DW/8-1:0]      wr_strb_i;
  logic                 wr_rsp_valid_o;
  logic [3:0]           mem_req_o;
  logic [3:0]           mem_gnt_i;
  logic [3:0][5:0]      mem_addr_o;
  logic [3:0]           mem_we_o;
  logic [3:0][DW-1:0]   mem_wdata_o;
  logic [3:0][DW/8-1:0] mem_strb_o;
  logic [3:0][DW-1:0]   mem_rdata_i;

  always #5 clk_i = ~clk_i;

  vector_fp_regfile dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .raddr_i(raddr_i), .ren_i(ren_i), .rtag_i(rtag_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .rdata_o(rdata_o), .rtag_o(rtag_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .wr_strb_i(wr_strb_i), .wr_rsp_valid_o(wr_rsp_valid_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o), .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [63:0] init_val(input int a);
    return {32'hC0DE0000 + 32'(a), 32'(a) ^ 32'h5A5A5A5A};
  endfunction

  // Banked memory: one-cycle read latency, byte-strobed writes
  logic [63:0] bank_mem [4][64];
  logic        mem_clr;
  always @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_clr) begin
        for (int r = 0; r < 64; r++) bank_mem[b][r] <= init_val(r * 4 + b);
      end else if (mem_req_o[b] && mem_gnt_i[b]) begin
        if (mem_we_o[b]) begin
          for (int k = 0; k < 8; k++)
            if (mem_strb_o[b][k]) bank_mem[b][mem_addr_o[b]][k*8 +: 8] <= mem_wdata_o[b][k*8 +: 8];
        end else begin
          mem_rdata_i[b] <= bank_mem[b][mem_addr_o[b]];
        end
      end
    end
  end

  typedef struct packed {
    logic [2:0][63:0] d;
    logic [7:0]       tag;
  } exp_t;

  logic [63:0]  ref_rf [256];
  exp_t         exp_q [$];
  int           n_vec = 0;
  int           n_err = 0;
  int           stall_cnt;
  bit           rand_rdy, rand_gnt, prev_stall;
  logic [199:0] prev_obs;

  task automatic chk(input string tag, input logic [207:0] got, input logic [207:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic mon();
    exp_t e;
    if (rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("hold", {rvalid_o, rdata_o, rtag_o}, {1'b1, prev_obs});
      if (rvalid_o && rready_i) begin
        n_vec++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_result observed=%h expected=none", {rdata_o, rtag_o});
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("result", {rdata_o, rtag_o}, e);
        end
      end
      prev_stall = rvalid_o && !rready_i;
      prev_obs   = {rdata_o, rtag_o};
    end
  endtask

  task automatic sample();
    @(negedge clk_i);
    mon();
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
    if (stall_cnt > 0) begin
      rready_i = 1'b0;
      stall_cnt--;
    end else if (rand_rdy) begin
      rready_i = ($urandom_range(0, 3) != 0);
    end else begin
      rready_i = 1'b1;
    end
    mem_gnt_i = rand_gnt ? 4'($urandom) : 4'hF;
  endtask

  task automatic do_read(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                         input logic [2:0] en, input logic [7:0] tg, output int cyc);
    bit   ok;
    exp_t e;
    raddr_i  = {a2, a1, a0};
    ren_i    = en;
    rtag_i   = tg;
    rvalid_i = 1'b1;
    cyc      = 0;
    ok       = 1'b0;
    while (!ok && cyc < 200) begin
      sample();
      cyc++;
      if (rready_o) begin
        ok    = 1'b1;
        e.tag = tg;
        e.d[0] = en[0] ? ref_rf[a0] : 64'h0;
        e.d[1] = en[1] ? ref_rf[a1] : 64'h0;
        e.d[2] = en[2] ? ref_rf[a2] : 64'h0;
        exp_q.push_back(e);
      end
      adv();
    end
    rvalid_i = 1'b0;
    chk("read_accept", ok, 1'b1);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [63:0] d, input logic [7:0] s);
    bit ok;
    int cyc;
    wr_addr_i  = a;
    wr_data_i  = d;
    wr_strb_i  = s;
    wr_valid_i = 1'b1;
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < 200) begin
      sample();
      cyc++;
      if (wr_ready_o) begin
        ok = 1'b1;
        for (int k = 0; k < 8; k++) if (s[k]) ref_rf[a][k*8 +: 8] = d[k*8 +: 8];
      end
      adv();
    end
    wr_valid_i = 1'b0;
    chk("write_accept", ok, 1'b1);
    sample();
    chk("wr_rsp", wr_rsp_valid_o, ok);
    adv();
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      sample();
      adv();
      w++;
    end
    chk("drain_empty", 208'(exp_q.size()), 208'd0);
  endtask

  initial begin
    int cyc;
    rst_i = 1'b1; rvalid_i = 1'b1; ren_i = 3'b111; raddr_i = '0; rtag_i = '0; rready_i = 1'b1;
    wr_valid_i = 1'b1; wr_addr_i = '0; wr_data_i = '0; wr_strb_i = '1; mem_gnt_i = 4'hF;
    mem_clr = 1'b1; stall_cnt = 0; rand_rdy = 1'b0; rand_gnt = 1'b0; prev_stall = 1'b0;
    prev_obs = '0;
    for (int a = 0; a < 256; a++) ref_rf[a] = init_val(a);

    sample();
    chk("reset_outs", {rvalid_o, rready_o, wr_ready_o, wr_rsp_valid_o, mem_req_o}, '0);
    adv();
    rvalid_i = 1'b0; wr_valid_i = 1'b0; mem_clr = 1'b0;
    adv();
    rst_i = 1'b0;
    adv();

    do_write(8'h05, 64'hDEAD, 8'hFF);
    chk("bank1_row1", bank_mem[1][1], 64'hDEAD);

    do_read(8'h04, 8'h05, 8'h06, 3'b111, 8'h3C, cyc);
    chk("lat_accept", cyc, 1);
    sample();
    chk("lat_rvalid", rvalid_o, 1'b1);
    chk("tag_3c", rtag_o, 8'h3C);
    chk("rdata1_dead", rdata_o[1], 64'hDEAD);
    adv();

    do_read(8'h00, 8'h05, 8'h00, 3'b010, 8'h11, cyc);
    sample();
    chk("en_010", {rvalid_o, rdata_o}, {1'b1, 64'h0, 64'hDEAD, 64'h0});
    adv();

    do_read(8'h10, 8'h20, 8'h30, 3'b000, 8'h77, cyc);
    sample();
    chk("en_000", {rvalid_o, rdata_o, rtag_o}, {1'b1, 192'h0, 8'h77});
    adv();

    do_read(8'h00, 8'h04, 8'h08, 3'b111, 8'h28, cyc);
    chk("serial_cycles", cyc, 3);
    sample();
    chk("serial_rvalid", rvalid_o, 1'b1);
    adv();

    rready_i  = 1'b0;
    stall_cnt = 4;
    for (int n = 0; n < 4; n++)
      do_read(8'($urandom), 8'($urandom), 8'($urandom), 3'b111, 8'(8'hA0 + n), cyc);
    drain();

    stall_cnt = 1000;
    rready_i  = 1'b0;
    do_read(8'h01, 8'h02, 8'h03, 3'b111, 8'h99, cyc);
    adv();
    rst_i = 1'b1;
    sample();
    chk("reset_mid", {rvalid_o, rready_o, wr_ready_o, wr_rsp_valid_o, mem_req_o}, '0);
    exp_q.delete();
    adv();
    rst_i     = 1'b0;
    stall_cnt = 0;
    rready_i  = 1'b1;
    adv();
    sample();
    chk("no_stale", rvalid_o, 1'b0);
    adv();
    do_read(8'h01, 8'h02, 8'h03, 3'b111, 8'h9A, cyc);
    sample();
    chk("post_reset_rvalid", rvalid_o, 1'b1);
    adv();

    rand_gnt = 1'b1;
    for (int n = 0; n < 24; n++)
      do_write(8'($urandom), {$urandom, $urandom}, 8'($urandom));
    rand_rdy = 1'b1;
    for (int n = 0; n < 40; n++)
      do_read(8'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), 8'($urandom), cyc);
    rand_rdy = 1'b0;
    rand_gnt = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
